// File: rtl/traffic.sv
// Traffic-light sequencer: RED -> GREEN -> YELLOW -> ALLRED, each dwelling a whole
// number of prescaled ticks, with a pedestrian walk lamp that flashes at the end of RED.
//
// state  | meaning
// -------+-----------------------------------------------
// RED    | red lamp; walk on, then flashing for the last FLASH_TICKS
// GREEN  | green lamp
// YELLOW | yellow lamp
// ALLRED | red lamp, walk off; clearance before RED
module traffic #(
    parameter int PRESCALE     = 3333333,
    parameter int RED_TICKS    = 6,
    parameter int GREEN_TICKS  = 6,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int FLASH_TICKS  = 2
) (
    input  logic clock,
    input  logic reset,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_ALLRED = 2'd3
    } state_t;

    localparam int PW    = $clog2(PRESCALE) + 1;
    localparam int MAX_A = (RED_TICKS > GREEN_TICKS) ? RED_TICKS : GREEN_TICKS;
    localparam int MAX_B = (YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS;
    localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int DW    = $clog2(MAXD) + 1;

    localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] RED_LAST    = DW'(RED_TICKS - 1);
    localparam logic [DW-1:0] GREEN_LAST  = DW'(GREEN_TICKS - 1);
    localparam logic [DW-1:0] YELLOW_LAST = DW'(YELLOW_TICKS - 1);
    localparam logic [DW-1:0] ALLRED_LAST = DW'(ALLRED_TICKS - 1);
    localparam logic [DW-1:0] FLASH_START = DW'(RED_TICKS - FLASH_TICKS);

    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    state_t        state_q, state_d;
    logic          tick;
    logic [DW-1:0] dwell_last;

    assign tick = (presc_q == PRE_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        dwell_last = RED_LAST;
        case (state_q)
            S_RED:    dwell_last = RED_LAST;
            S_GREEN:  dwell_last = GREEN_LAST;
            S_YELLOW: dwell_last = YELLOW_LAST;
            S_ALLRED: dwell_last = ALLRED_LAST;
            default:  dwell_last = RED_LAST;
        endcase
        if (tick) begin
            if (dwell_q == dwell_last) begin
                dwell_d = '0;
                case (state_q)
                    S_RED:    state_d = S_GREEN;
                    S_GREEN:  state_d = S_YELLOW;
                    S_YELLOW: state_d = S_ALLRED;
                    S_ALLRED: state_d = S_RED;
                    default:  state_d = S_RED;
                endcase
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            dwell_q <= '0;
            state_q <= S_RED;
        end else begin
            presc_q <= presc_d;
            dwell_q <= dwell_d;
            state_q <= state_d;
        end
    end

    // Bit 0 of (dwell - FLASH_START) equals the XOR of the two low bits.
    always_comb begin
        LED2 = 1'b0;
        LED3 = 1'b0;
        LED4 = 1'b0;
        LED5 = 1'b0;
        case (state_q)
            S_RED: begin
                LED2 = 1'b1;
                LED5 = (dwell_q < FLASH_START) ? 1'b1 : (dwell_q[0] ^ FLASH_START[0]);
            end
            S_GREEN:  LED4 = 1'b1;
            S_YELLOW: LED3 = 1'b1;
            S_ALLRED: LED2 = 1'b1;
            default:  LED2 = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_traffic.sv
// Directed bench for traffic: reset values, full sequence timing, walk flashing,
// minimum-duration timing, asynchronous mid-cycle reset and lamp invariants.
module tb_traffic;

    logic clk = 1'b0;
    logic rst_def, rst_a, rst_b;
    logic d2, d3, d4, d5;
    logic a2, a3, a4, a5;
    logic b2, b3, b4, b5;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    traffic u_def (
        .clock(clk), .reset(rst_def),
        .LED2(d2), .LED3(d3), .LED4(d4), .LED5(d5)
    );

    traffic #(
        .PRESCALE(2), .RED_TICKS(5), .GREEN_TICKS(5),
        .YELLOW_TICKS(2), .ALLRED_TICKS(1), .FLASH_TICKS(2)
    ) u_a (
        .clock(clk), .reset(rst_a),
        .LED2(a2), .LED3(a3), .LED4(a4), .LED5(a5)
    );

    traffic #(
        .PRESCALE(1), .RED_TICKS(2), .GREEN_TICKS(1),
        .YELLOW_TICKS(1), .ALLRED_TICKS(1), .FLASH_TICKS(1)
    ) u_b (
        .clock(clk), .reset(rst_b),
        .LED2(b2), .LED3(b3), .LED4(b4), .LED5(b5)
    );

    // Hand-derived lamp pattern {LED2,LED3,LED4,LED5} for u_a, cycle c after release.
    // RED 0-9 (walk 1 for 0-5, 0 for 6-7, 1 for 8-9), GREEN 10-19, YELLOW 20-23, ALLRED 24-25.
    function automatic logic [3:0] exp_a(input int c);
        int m;
        m = c % 26;
        if (m < 6)       return 4'b1001;
        else if (m < 8)  return 4'b1000;
        else if (m < 10) return 4'b1001;
        else if (m < 20) return 4'b0010;
        else if (m < 24) return 4'b0100;
        else             return 4'b1000;
    endfunction

    task automatic test_reset();
        rst_def = 1'b0;
        rst_a   = 1'b0;
        rst_b   = 1'b0;
        #1;
        tests_run++;
        if ({d2, d3, d4, d5} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL reset_async_def: got %b want 1001", {d2, d3, d4, d5});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if ({d2, d3, d4, d5} !== 4'b1001) begin
                tests_failed++;
                $display("FAIL reset_hold_def cycle %0d: got %b want 1001", i, {d2, d3, d4, d5});
            end
            tests_run++;
            if ({a2, a3, a4, a5} !== 4'b1001 || {b2, b3, b4, b5} !== 4'b1001) begin
                tests_failed++;
                $display("FAIL reset_hold_small cycle %0d: got a=%b b=%b want 1001",
                         i, {a2, a3, a4, a5}, {b2, b3, b4, b5});
            end
        end
    endtask

    task automatic test_full_cycle();
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            tests_run++;
            if ({a2, a3, a4, a5} !== exp_a(c)) begin
                tests_failed++;
                $display("FAIL full_cycle cycle %0d: got %b want %b", c, {a2, a3, a4, a5}, exp_a(c));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_walk_flash();
        logic w;
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c < 6)       w = 1'b1;
            else if (c < 8)  w = 1'b0;
            else if (c < 10) w = 1'b1;
            else if (c < 26) w = 1'b0;
            else             w = 1'b1;
            #1;
            tests_run++;
            if (a5 !== w) begin
                tests_failed++;
                $display("FAIL walk_flash cycle %0d: got %b want %b", c, a5, w);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_min_timing();
        logic [3:0] pat [5];
        pat[0] = 4'b1001;
        pat[1] = 4'b1000;
        pat[2] = 4'b0010;
        pat[3] = 4'b0100;
        pat[4] = 4'b1000;
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            tests_run++;
            if ({b2, b3, b4, b5} !== pat[c % 5]) begin
                tests_failed++;
                $display("FAIL min_timing cycle %0d: got %b want %b", c, {b2, b3, b4, b5}, pat[c % 5]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 0; c < 21; c++) @(negedge clk);
        #1;
        tests_run++;
        if ({a2, a3, a4, a5} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL mid_reset_pre_yellow: got %b want 0100", {a2, a3, a4, a5});
        end
        #2;
        rst_a = 1'b0;
        #1;
        tests_run++;
        if ({a2, a3, a4, a5} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got %b want 1001", {a2, a3, a4, a5});
        end
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            tests_run++;
            if ({a2, a3, a4, a5} !== exp_a(c)) begin
                tests_failed++;
                $display("FAIL mid_reset_after cycle %0d: got %b want %b", c, {a2, a3, a4, a5}, exp_a(c));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invariants();
        for (int i = 0; i < 1000; i++) begin
            rst_a = ($urandom_range(0, 49) != 0);
            rst_b = ($urandom_range(0, 49) != 0);
            #1;
            tests_run++;
            if ((32'(a2) + 32'(a3) + 32'(a4)) != 1 || (a5 && !a2)) begin
                tests_failed++;
                $display("FAIL invariant_a cycle %0d: got %b want one-hot red/yellow/green, walk only with red",
                         i, {a2, a3, a4, a5});
            end
            tests_run++;
            if ((32'(b2) + 32'(b3) + 32'(b4)) != 1 || (b5 && !b2)) begin
                tests_failed++;
                $display("FAIL invariant_b cycle %0d: got %b want one-hot red/yellow/green, walk only with red",
                         i, {b2, b3, b4, b5});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_walk_flash();
        test_min_timing();
        test_mid_reset();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/traffic.md
TRAFFIC -- requirements
Module: traffic

Interface
REQ-001 Parameter PRESCALE, default 3333333: clock cycles per timing tick (1 s at the 3.33 MHz board clock); legal range >= 1.
REQ-002 Parameter RED_TICKS, default 6: ticks spent in RED; must be >= 2.
REQ-003 Parameter GREEN_TICKS, default 6: ticks spent in GREEN; must be >= 1.
REQ-004 Parameter YELLOW_TICKS, default 2: ticks spent in YELLOW; must be >= 1.
REQ-005 Parameter ALLRED_TICKS, default 1: ticks spent in ALLRED clearance; must be >= 1.
REQ-006 Parameter FLASH_TICKS, default 2: trailing RED ticks with a flashing walk lamp; must be >= 1 and < RED_TICKS.
REQ-007 clock  input  1  single system clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 LED2  output  1  red lamp, active-high.
REQ-010 LED3  output  1  yellow lamp, active-high.
REQ-011 LED4  output  1  green lamp, active-high.
REQ-012 LED5  output  1  pedestrian walk lamp, active-high.

Function
REQ-013 Prescale counter: width $clog2(PRESCALE)+1 bits; counts 0..PRESCALE-1 and then wraps to 0; tick is asserted in the cycle where the counter equals PRESCALE-1; with PRESCALE=1, tick is asserted every cycle.
REQ-014 Dwell counter: counts ticks within the current state; it is wide enough for the largest duration parameter.
REQ-015 State machine states: RED, GREEN, YELLOW, ALLRED.
REQ-016 Transition order: RED -> GREEN -> YELLOW -> ALLRED -> RED, repeating indefinitely with no other transitions.
REQ-017 A state is left at the clock edge where tick=1 and dwell = duration-1; the dwell counter clears to 0 on that edge.
REQ-018 When tick=1 and dwell < duration-1, dwell increments; when tick=0, dwell holds.
REQ-019 Each state therefore lasts exactly duration*PRESCALE clock cycles.
REQ-020 Lamp decode: RED drives LED2=1; GREEN drives LED4=1; YELLOW drives LED3=1; ALLRED drives LED2=1; all lamps not listed for a state are 0.
REQ-021 Walk lamp LED5 is 0 in every state except RED.
REQ-022 In RED, LED5=1 while dwell < RED_TICKS-FLASH_TICKS.
REQ-023 In RED, for the trailing ticks, LED5 = bit 0 of (dwell-(RED_TICKS-FLASH_TICKS)): off on the first flash tick, then alternating each tick.
REQ-024 Outputs are decoded only from the state, dwell and prescale registers, with no input-to-output combinational path.
REQ-025 Exactly one of LED2/LED3/LED4 is 1 at all times after reset; LED5=1 is permitted only together with LED2=1.

Reset
REQ-026 While reset=0, regardless of clock: state=RED, dwell=0, prescale counter=0.
REQ-027 While reset=0, outputs are LED2=1, LED3=0, LED4=0, LED5=1.
REQ-028 After reset deasserts, the first tick occurs PRESCALE cycles later, and RED lasts a full RED_TICKS*PRESCALE cycles.
REQ-029 Reset asserted mid-cycle in any state returns the design to the REQ-026/REQ-027 values immediately (asynchronously), discarding all partial counts.

Verification
REQ-030 Reset check (defaults): hold reset=0 for 5 cycles -> LED2..LED5 = 1,0,0,1 throughout.
REQ-031 Full cycle, PRESCALE=2, RED=5, GREEN=5, YELLOW=2, ALLRED=1, FLASH=2 -> expected durations after release: RED for cycles 0-9, GREEN 10-19, YELLOW 20-23, ALLRED 24-25; the sequence returns to RED at cycle 26 with a period of 26.
REQ-032 Walk flash, same parameters -> LED5=1 during cycles 0-5, LED5=0 during cycles 6-7, LED5=1 during cycles 8-9, LED5=0 from cycle 10 onward until the next RED.
REQ-033 PRESCALE=1, all durations 1 except RED=2 and FLASH=1 -> state advances every cycle except RED, which lasts 2 cycles; LED5 pattern in RED is 1 then 0.
REQ-034 Mid-operation reset: assert reset=0 during YELLOW -> outputs go to 1,0,0,1 without waiting for a clock edge; after release, a full RED of RED_TICKS*PRESCALE cycles follows.
REQ-035 Invariant monitor over 1000 cycles with random reset pulses -> LED2+LED3+LED4 = 1 in every cycle, and LED5 is never 1 unless LED2=1.
